and_hpc2_pipe: RTL and testbench

- Pipelined, W-bit-wide, N-share masked AND gadget using the HPC2 construction.
- Sits directly upstream of the share-wise masked XOR stage. It produces the c shares that the XOR layer combines with linear terms.
- Adds valid tracking and a global stall enable around the 2-register-deep HPC2 datapath, so the nonlinear layer can be chained without external control.

---
 rtl/and_hpc2_pipe_pkg.sv | 21 ++
 rtl/and_hpc2_pipe_if.sv | 22 ++
 rtl/hpc2_cross_term.sv | 41 ++++
 rtl/and_hpc2_pipe.sv | 78 +++++++
 tb/tb_and_hpc2_pipe.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/and_hpc2_pipe_pkg.sv
// rtl/and_hpc2_pipe_pkg.sv - shared masking helpers for the HPC2 AND pipeline
package and_hpc2_pipe_pkg;

    function automatic int npairs(input int n);
        return n * (n - 1) / 2;
    endfunction

    // Unordered pair (i,j) -> randomness slice index, enumerated i ascending then j ascending.
    function automatic int pair_index(input int i, input int j, input int n);
        int lo;
        int hi;
        lo = (i < j) ? i : j;
        hi = (i < j) ? j : i;
        return lo * n - (lo * (lo + 1)) / 2 + (hi - lo - 1);
    endfunction

    function automatic int share_lo(input int i, input int w);
        return i * w;
    endfunction

endpackage

// File: rtl/and_hpc2_pipe_if.sv
// rtl/and_hpc2_pipe_if.sv - operand/result bundle for the HPC2 AND pipeline
interface and_hpc2_pipe_if
    import and_hpc2_pipe_pkg::*;
#(
    parameter int N = 3,
    parameter int W = 1
);
    localparam int RW = W * npairs(N);

    logic          en;
    logic          in_valid;
    logic [N*W-1:0] a;
    logic [N*W-1:0] b;
    logic [RW-1:0]  r;
    logic [N*W-1:0] c;
    logic          out_valid;

    modport master (output en, output in_valid, output a, output b, output r,
                    input c, input out_valid);
    modport slave  (input en, input in_valid, input a, input b, input r,
                    output c, output out_valid);
endinterface

// File: rtl/hpc2_cross_term.sv
// rtl/hpc2_cross_term.sv - one ordered-pair HPC2 cross term, two register stages
module hpc2_cross_term #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_j,
    input  logic [W-1:0] r_ij,
    input  logic [W-1:0] a1_i,
    input  logic         ld1,
    input  logic         ld2,
    output logic [W-1:0] term_o
);
    logic [W-1:0] u1_q, v1_q, u2_q, x2_q;
    logic [W-1:0] u1_d, v1_d, u2_d, x2_d;

    always_comb begin
        u1_d = ld1 ? (~a_i & r_ij) : u1_q;
        v1_d = ld1 ? (b_j ^ r_ij)  : v1_q;
        u2_d = ld2 ? u1_q          : u2_q;
        x2_d = ld2 ? (a1_i & v1_q) : x2_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            u1_q <= '0;
            v1_q <= '0;
            u2_q <= '0;
            x2_q <= '0;
        end else begin
            u1_q <= u1_d;
            v1_q <= v1_d;
            u2_q <= u2_d;
            x2_q <= x2_d;
        end
    end

    // Both halves are registered before combining so glitches never mix a_i with b_j unmasked.
    assign term_o = u2_q ^ x2_q;
endmodule

// File: rtl/and_hpc2_pipe.sv
// rtl/and_hpc2_pipe.sv - pipelined N-share, W-lane HPC2 masked AND with valid and stall
module and_hpc2_pipe
    import and_hpc2_pipe_pkg::*;
#(
    parameter int N = 3,
    parameter int W = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    and_hpc2_pipe_if.slave bus
);
    logic ld1, ld2;
    logic v1_q, v2_q, v1_d, v2_d;
    logic [N*W-1:0] a1_q, p1_q, p2_q;
    logic [N*W-1:0] a1_d, p1_d, p2_d;
    logic [N*W-1:0] c_comb;
    logic [W-1:0]   term [N][N];

    assign ld1 = bus.en & bus.in_valid;
    assign ld2 = bus.en & v1_q;

    always_comb begin
        v1_d = bus.en ? bus.in_valid : v1_q;
        v2_d = bus.en ? v1_q         : v2_q;
        a1_d = ld1 ? bus.a           : a1_q;
        p1_d = ld1 ? (bus.a & bus.b) : p1_q;
        p2_d = ld2 ? p1_q            : p2_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            a1_q <= '0;
            p1_q <= '0;
            p2_q <= '0;
        end else begin
            v1_q <= v1_d;
            v2_q <= v2_d;
            a1_q <= a1_d;
            p1_q <= p1_d;
            p2_q <= p2_d;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            if (i != j) begin : g_ct
                hpc2_cross_term #(.W(W)) u_ct (
                    .clk    (clk),
                    .rst_n  (rst_n),
                    .a_i    (bus.a[share_lo(i, W) +: W]),
                    .b_j    (bus.b[share_lo(j, W) +: W]),
                    .r_ij   (bus.r[pair_index(i, j, N) * W +: W]),
                    .a1_i   (a1_q[share_lo(i, W) +: W]),
                    .ld1    (ld1),
                    .ld2    (ld2),
                    .term_o (term[i][j])
                );
            end else begin : g_diag
                assign term[i][j] = '0;
            end
        end
    end

    // Compression uses stage-2 registers only; never pull stage-1 values into this XOR.
    always_comb begin
        c_comb = p2_q;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                c_comb[i*W +: W] = c_comb[i*W +: W] ^ term[i][j];
            end
        end
    end

    assign bus.c         = c_comb;
    assign bus.out_valid = v2_q;
endmodule

// File: tb/tb_and_hpc2_pipe.sv
// tb/tb_and_hpc2_pipe.sv - directed self-checking bench for and_hpc2_pipe
module tb_and_hpc2_pipe;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    and_hpc2_pipe_if #(.N(3), .W(1)) bus3 ();
    and_hpc2_pipe_if #(.N(2), .W(4)) bus4 ();

    and_hpc2_pipe #(.N(3), .W(1)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));
    and_hpc2_pipe #(.N(2), .W(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

    always #5 clk = ~clk;

    // Reference for N=3: c_i = a_i & XOR(b) ^ XOR of r over pairs touching i.
    function automatic logic [2:0] model3(input logic [2:0] a, input logic [2:0] b,
                                          input logic [2:0] r);
        logic xb;
        logic [2:0] c;
        xb   = ^b;
        c[0] = (a[0] & xb) ^ r[0] ^ r[1];
        c[1] = (a[1] & xb) ^ r[0] ^ r[2];
        c[2] = (a[2] & xb) ^ r[1] ^ r[2];
        return c;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive3(input logic v, input logic [2:0] a, input logic [2:0] b,
                          input logic [2:0] r);
        bus3.in_valid = v;
        bus3.a = a;
        bus3.b = b;
        bus3.r = r;
    endtask

    task automatic test_reset();
        #1;
        checks += 2;
        if (bus3.c !== 3'b000) begin errors++; $display("FAIL reset_c3 got %b want 000", bus3.c); end
        if (bus3.out_valid !== 1'b0) begin errors++; $display("FAIL reset_ov3 got %b want 0", bus3.out_valid); end
        step();
        checks += 2;
        if (bus4.c !== 8'h00) begin errors++; $display("FAIL reset_c4 got %h want 00", bus4.c); end
        if (bus4.out_valid !== 1'b0) begin errors++; $display("FAIL reset_ov4 got %b want 0", bus4.out_valid); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        drive3(1'b1, 3'b111, 3'b100, 3'b000);
        step();
        drive3(1'b0, 3'b000, 3'b000, 3'b000);
        step();
        checks += 2;
        if (bus3.out_valid !== 1'b1) begin errors++; $display("FAIL basic_ov got %b want 1", bus3.out_valid); end
        if (bus3.c !== 3'b111) begin errors++; $display("FAIL basic_c got %b want 111", bus3.c); end
        step();
        checks += 2;
        if (bus3.out_valid !== 1'b0) begin errors++; $display("FAIL basic_ov_drop got %b want 0", bus3.out_valid); end
        if (bus3.c !== 3'b111) begin errors++; $display("FAIL basic_hold got %b want 111", bus3.c); end
        drive3(1'b1, 3'b111, 3'b100, 3'b101);
        step();
        drive3(1'b0, 3'b000, 3'b000, 3'b000);
        step();
        checks += 2;
        if (bus3.c !== 3'b010) begin errors++; $display("FAIL basic_r101_c got %b want 010", bus3.c); end
        if ((^bus3.c) !== 1'b1) begin errors++; $display("FAIL basic_r101_xor got %b want 1", ^bus3.c); end
    endtask

    task automatic test_exhaustive();
        logic [2:0] a, b, r, exp;
        for (int ai = 0; ai < 8; ai++) begin
            for (int bi = 0; bi < 8; bi++) begin
                for (int ri = 0; ri < 8; ri++) begin
                    a = 3'(ai);
                    b = 3'(bi);
                    r = 3'(ri);
                    exp = model3(a, b, r);
                    drive3(1'b1, a, b, r);
                    step();
                    drive3(1'b0, 3'b000, 3'b000, 3'b000);
                    step();
                    checks += 2;
                    if (bus3.c !== exp || bus3.out_valid !== 1'b1) begin
                        errors++;
                        $display("FAIL exh_c a=%b b=%b r=%b got %b/%b want %b/1", a, b, r, bus3.c, bus3.out_valid, exp);
                    end
                    if ((^bus3.c) !== ((^a) & (^b))) begin
                        errors++;
                        $display("FAIL exh_xor a=%b b=%b r=%b got %b want %b", a, b, r, ^bus3.c, (^a) & (^b));
                    end
                end
            end
        end
    endtask

    logic [2:0] bb_a [4] = '{3'b001, 3'b001, 3'b011, 3'b000};
    logic [2:0] bb_b [4] = '{3'b001, 3'b000, 3'b111, 3'b110};
    logic [2:0] bb_r [4] = '{3'b110, 3'b011, 3'b101, 3'b111};
    logic       bb_u [4] = '{1'b1, 1'b0, 1'b0, 1'b0};

    task automatic test_back_to_back();
        for (int k = 0; k < 6; k++) begin
            if (k < 4) drive3(1'b1, bb_a[k], bb_b[k], bb_r[k]);
            else       drive3(1'b0, 3'b000, 3'b000, 3'b000);
            step();
            if (k >= 1 && k <= 4) begin
                checks += 3;
                if (bus3.out_valid !== 1'b1) begin errors++; $display("FAIL b2b_ov%0d got %b want 1", k - 1, bus3.out_valid); end
                if ((^bus3.c) !== bb_u[k-1]) begin errors++; $display("FAIL b2b_unmasked%0d got %b want %b", k - 1, ^bus3.c, bb_u[k-1]); end
                if (bus3.c !== model3(bb_a[k-1], bb_b[k-1], bb_r[k-1])) begin
                    errors++;
                    $display("FAIL b2b_c%0d got %b want %b", k - 1, bus3.c, model3(bb_a[k-1], bb_b[k-1], bb_r[k-1]));
                end
            end else if (k == 5) begin
                checks++;
                if (bus3.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_tail_ov got %b want 0", bus3.out_valid); end
            end
        end
    endtask

    task automatic test_stall();
        logic [2:0] held, exp;
        held = model3(bb_a[3], bb_b[3], bb_r[3]);
        exp  = model3(3'b101, 3'b011, 3'b110);
        drive3(1'b1, 3'b101, 3'b011, 3'b110);
        step();
        bus3.en = 1'b0;
        drive3(1'b1, 3'b010, 3'b111, 3'b001);
        for (int s = 0; s < 3; s++) begin
            step();
            checks += 2;
            if (bus3.out_valid !== 1'b0) begin errors++; $display("FAIL stall_ov%0d got %b want 0", s, bus3.out_valid); end
            if (bus3.c !== held) begin errors++; $display("FAIL stall_c%0d got %b want %b", s, bus3.c, held); end
        end
        bus3.en = 1'b1;
        drive3(1'b0, 3'b000, 3'b000, 3'b000);
        step();
        checks += 2;
        if (bus3.out_valid !== 1'b1) begin errors++; $display("FAIL stall_result_ov got %b want 1", bus3.out_valid); end
        if (bus3.c !== exp) begin errors++; $display("FAIL stall_result_c got %b want %b", bus3.c, exp); end
        step();
        checks++;
        if (bus3.out_valid !== 1'b0) begin errors++; $display("FAIL stall_ignored_ov got %b want 0", bus3.out_valid); end
    endtask

    task automatic test_reset_midflight();
        drive3(1'b1, 3'b110, 3'b010, 3'b011);
        step();
        drive3(1'b0, 3'b000, 3'b000, 3'b000);
        #2;
        rst_n = 1'b0;
        #1;
        checks += 2;
        if (bus3.c !== 3'b000) begin errors++; $display("FAIL midrst_c got %b want 000", bus3.c); end
        if (bus3.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_ov got %b want 0", bus3.out_valid); end
        #1;
        rst_n = 1'b1;
        for (int s = 0; s < 3; s++) begin
            step();
            checks += 2;
            if (bus3.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_after_ov%0d got %b want 0", s, bus3.out_valid); end
            if (bus3.c !== 3'b000) begin errors++; $display("FAIL midrst_after_c%0d got %b want 000", s, bus3.c); end
        end
    endtask

    task automatic test_wide();
        logic [7:0] a, b;
        logic [3:0] r, exp;
        for (int n = 0; n < 8; n++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            r = 4'($urandom);
            exp = (a[3:0] ^ a[7:4]) & (b[3:0] ^ b[7:4]);
            bus4.in_valid = 1'b1;
            bus4.a = a;
            bus4.b = b;
            bus4.r = r;
            step();
            bus4.in_valid = 1'b0;
            checks++;
            if (bus4.out_valid !== 1'b0) begin errors++; $display("FAIL wide_early_ov%0d got %b want 0", n, bus4.out_valid); end
            step();
            checks += 2;
            if (bus4.out_valid !== 1'b1) begin errors++; $display("FAIL wide_ov%0d got %b want 1", n, bus4.out_valid); end
            if ((bus4.c[3:0] ^ bus4.c[7:4]) !== exp) begin
                errors++;
                $display("FAIL wide_and%0d a=%h b=%h r=%h got %h want %h", n, a, b, r, bus4.c[3:0] ^ bus4.c[7:4], exp);
            end
        end
    endtask

    initial begin
        clk = 1'b0;
        rst_n = 1'b0;
        checks = 0;
        errors = 0;
        bus3.en = 1'b1;
        drive3(1'b0, 3'b000, 3'b000, 3'b000);
        bus4.en = 1'b1;
        bus4.in_valid = 1'b0;
        bus4.a = '0;
        bus4.b = '0;
        bus4.r = '0;
        test_reset();
        test_basic();
        test_exhaustive();
        test_back_to_back();
        test_stall();
        test_reset_midflight();
        test_wide();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
